// File: rtl/vector_list_player_if.sv
// Display-list ROM port for vector_list_player.
// master: rom_addr out, rom_data in; slave: the ROM side.
`timescale 1ns/1ps
interface vector_list_player_if #(
    parameter int ADDRESSWIDTH = 8,
    parameter int DATAWIDTH    = 18
);
    logic [ADDRESSWIDTH-1:0] rom_addr;
    logic [DATAWIDTH-1:0]    rom_data;

    modport master (
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/vector_list_player.sv
// Walks a MOVE/DRAW/DOT/END display list from ROM once per frame_tick
// and steps registered x_ch/y_ch/beam_on toward each target.
// Ports: clk, rst (async active-low), enable, frame_tick, rom (master),
// x_ch, y_ch, beam_on, frame_done (1-cycle pulse), busy.
`timescale 1ns/1ps
module vector_list_player #(
    parameter int ADDRESSWIDTH  = 8,
    parameter int DAC_WIDTH     = 8,
    parameter int DATAWIDTH     = 2*DAC_WIDTH+2,
    parameter int ROM_LATENCY   = 0,
    parameter int STEP          = 1,
    parameter int SETTLE_CYCLES = 4,
    parameter int DOT_CYCLES    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 frame_tick,
    vector_list_player_if.master rom,
    output logic [DAC_WIDTH-1:0] x_ch,
    output logic [DAC_WIDTH-1:0] y_ch,
    output logic                 beam_on,
    output logic                 frame_done,
    output logic                 busy
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_EXEC   = 4'd2;
    localparam logic [3:0] S_SETTLE = 4'd3;
    localparam logic [3:0] S_DRAW   = 4'd4;
    localparam logic [3:0] S_DOT    = 4'd5;
    localparam logic [3:0] S_NEXT   = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;
    localparam logic [3:0] S_WAIT   = 4'd8;

    localparam int CNT_MAX = (SETTLE_CYCLES > DOT_CYCLES) ?
                             SETTLE_CYCLES : DOT_CYCLES;
    localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [DAC_WIDTH-1:0] MID = {1'b1, {(DAC_WIDTH-1){1'b0}}};

    logic [3:0]              state;
    logic [ADDRESSWIDTH-1:0] ptr;
    logic [DATAWIDTH-1:0]    ir;
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              lat;

    logic [1:0]           cmd;
    logic [DAC_WIDTH-1:0] tx;
    logic [DAC_WIDTH-1:0] ty;
    logic [DAC_WIDTH-1:0] nx_x;
    logic [DAC_WIDTH-1:0] nx_y;

    assign cmd = ir[DATAWIDTH-1 -: 2];
    assign tx  = ir[2*DAC_WIDTH-1 -: DAC_WIDTH];
    assign ty  = ir[DAC_WIDTH-1:0];

    // One extra bit keeps the +/-STEP arithmetic from wrapping; the
    // distance compare clamps the move so it lands exactly on target.
    function automatic logic [DAC_WIDTH-1:0] step_to(
        input logic [DAC_WIDTH-1:0] cur,
        input logic [DAC_WIDTH-1:0] tgt
    );
        logic [DAC_WIDTH:0] c;
        logic [DAC_WIDTH:0] t;
        logic [DAC_WIDTH:0] s;
        logic [DAC_WIDTH:0] n;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        s = (DAC_WIDTH+1)'(STEP);
        if (t > c) n = ((t - c) > s) ? c + s : t;
        else       n = ((c - t) > s) ? c - s : t;
        return n[DAC_WIDTH-1:0];
    endfunction

    assign nx_x = step_to(x_ch, tx);
    assign nx_y = step_to(y_ch, ty);

    assign busy = (state != S_IDLE) && (state != S_WAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            ptr          <= '0;
            rom.rom_addr <= '0;
            ir           <= '0;
            cnt          <= '0;
            lat          <= '0;
            x_ch         <= MID;
            y_ch         <= MID;
            beam_on      <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                S_IDLE, S_WAIT: begin
                    beam_on <= 1'b0;
                    if (frame_tick && enable) begin
                        state        <= S_FETCH;
                        ptr          <= '0;
                        rom.rom_addr <= '0;
                        lat          <= '0;
                    end
                end
                S_FETCH: begin
                    beam_on <= 1'b0;
                    if (lat == 2'(ROM_LATENCY)) begin
                        ir    <= rom.rom_data;
                        state <= S_EXEC;
                    end else begin
                        lat <= lat + 2'd1;
                    end
                end
                S_EXEC: begin
                    unique case (cmd)
                        2'b00: begin
                            x_ch    <= tx;
                            y_ch    <= ty;
                            beam_on <= 1'b0;
                            if (SETTLE_CYCLES > 0) begin
                                cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                                state <= S_SETTLE;
                            end else begin
                                state <= S_NEXT;
                            end
                        end
                        2'b01: state <= S_DRAW;
                        2'b10: begin
                            // Beam rises with the jump so the dwell
                            // covers exactly the DOT state cycles.
                            x_ch    <= tx;
                            y_ch    <= ty;
                            beam_on <= 1'b1;
                            cnt     <= CNT_W'(DOT_CYCLES - 1);
                            state   <= S_DOT;
                        end
                        default: state <= S_DONE;
                    endcase
                end
                S_SETTLE: begin
                    beam_on <= 1'b0;
                    if (cnt == '0) state <= S_NEXT;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                S_DRAW: begin
                    x_ch    <= nx_x;
                    y_ch    <= nx_y;
                    beam_on <= 1'b1;
                    if (nx_x == tx && nx_y == ty) state <= S_NEXT;
                end
                S_DOT: begin
                    if (cnt == '0) begin
                        beam_on <= 1'b0;
                        state   <= S_NEXT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    beam_on <= 1'b0;
                    if (ptr == {ADDRESSWIDTH{1'b1}}) begin
                        state <= S_DONE;
                    end else begin
                        ptr <= ptr + ADDRESSWIDTH'(1);
                        if (!enable) begin
                            state <= S_IDLE;
                        end else begin
                            state        <= S_FETCH;
                            rom.rom_addr <= ptr + ADDRESSWIDTH'(1);
                            lat          <= '0;
                        end
                    end
                end
                S_DONE: begin
                    beam_on      <= 1'b0;
                    frame_done   <= 1'b1;
                    ptr          <= '0;
                    rom.rom_addr <= '0;
                    state        <= S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/vector_list_player.md
Name: vector_list_player

Overview:
- Parametrised successor to the fixed ROM-plus-display pairing in the vector display top.
- Walks a display list held in an external ROM with configurable read latency.
- Decodes each word into MOVE / DRAW / DOT / END commands and steps the beam toward each target at a programmable rate, producing DAC-width x/y channels plus a beam-enable.
- Replays the list once per frame strobe; sits between the list ROM and the X/Y DAC outputs.

Parameters:
- ADDRESSWIDTH, 8, ROM address width; list length up to 2^ADDRESSWIDTH words.
- DAC_WIDTH, 8, x/y coordinate and output channel width.
- DATAWIDTH, 2*DAC_WIDTH+2 (18), ROM word width; layout [DATAWIDTH-1:DATAWIDTH-2]=cmd, next DAC_WIDTH bits=x, low DAC_WIDTH bits=y.
- ROM_LATENCY, 0, cycles from rom_addr change to valid rom_data; legal range 0..3.
- STEP, 1, per-axis increment per cycle during DRAW; 1..2^DAC_WIDTH-1.
- SETTLE_CYCLES, 4, beam-off dwell after a MOVE; 0 is legal.
- DOT_CYCLES, 8, beam-on dwell for DOT; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  allows a frame to start.
- frame_tick  in  1  single-cycle strobe that starts the next frame.
- rom_addr  out  ADDRESSWIDTH  registered ROM address.
- rom_data  in  DATAWIDTH  ROM read data.
- x_ch  out  DAC_WIDTH  X DAC code, registered.
- y_ch  out  DAC_WIDTH  Y DAC code, registered.
- beam_on  out  1  beam/Z enable, registered.
- frame_done  out  1  one-cycle pulse at end of list.
- busy  out  1  high in every state except IDLE and WAIT_FRAME.

Behaviour:
- Command encoding: 00 MOVE, 01 DRAW, 10 DOT, 11 END.
- Reset (rst=0, asynchronous):
  - state = IDLE, ptr = 0, rom_addr = 0.
  - x_ch = y_ch = 2^(DAC_WIDTH-1) (mid-scale).
  - beam_on = 0, frame_done = 0, busy = 0.
- IDLE and WAIT_FRAME:
  - beam_on = 0; x/y hold.
  - frame_tick=1 and enable=1 in the same cycle -> FETCH, ptr = 0.
  - frame_tick while enable=0 is ignored.
- FETCH:
  - rom_addr = ptr.
  - Stays ROM_LATENCY+1 cycles, then captures rom_data into the instruction register on the last edge and goes to EXEC.
  - beam_on = 0.
- EXEC (1 cycle):
  - MOVE: x/y loaded with target, beam_on = 0. If SETTLE_CYCLES > 0 -> SETTLE (counter loaded); else -> NEXT.
  - DRAW: -> DRAW; x/y unchanged this cycle.
  - DOT: x/y loaded with target -> DOT (counter = DOT_CYCLES).
  - END: -> DONE.
- SETTLE: counter decrements each cycle; beam_on = 0; at 0 -> NEXT.
- DRAW:
  - beam_on = 1.
  - Each cycle, each axis independently moves toward its target by min(STEP, |target - current|).
  - Unsigned arithmetic in DAC_WIDTH+1 bits; never overshoots and never wraps.
  - On the cycle both axes equal the target -> NEXT; beam_on drops in NEXT.
  - Zero-length DRAW (target == current) spends exactly 1 DRAW cycle with beam_on = 1.
- DOT: beam_on = 1 for exactly DOT_CYCLES cycles -> NEXT.
- NEXT (1 cycle, beam_on = 0):
  - If ptr == 2^ADDRESSWIDTH-1 -> DONE (implicit END, no address wrap into a new frame).
  - Otherwise ptr += 1.
  - If enable=0 -> IDLE (stop at instruction boundary); else -> FETCH.
- DONE (1 cycle):
  - frame_done = 1, ptr = 0, rom_addr = 0 -> WAIT_FRAME.
  - x/y hold at the last position.
- frame_tick outside IDLE/WAIT_FRAME is ignored; there is no queuing.
- enable deassert mid-instruction completes that instruction, then stops in NEXT.
- Reset mid-operation returns immediately to reset values.
- Outputs change only on clk edges; no combinational path from any input to any output.

Test Plan:
- Reset/idle: assert rst=0 mid-DRAW -> x_ch=y_ch=0x80, beam_on=0, busy=0, rom_addr=0 immediately; no activity until frame_tick with enable=1.
- MOVE+DRAW, STEP=1, ROM_LATENCY=0:
  - List {MOVE(0x10,0x10), DRAW(0x14,0x12), END}.
  - Required: x/y=0x10 with beam_on=0 for 4 settle cycles.
  - Then x runs 0x11..0x14 while y runs 0x11,0x12 then holds; beam_on=1 for exactly 4 cycles.
  - Then frame_done pulses once.
- Step clamp, STEP=3: DRAW from (0x00,0xFF) to (0x07,0xF9) -> x 3,6,7 and y 0xFC,0xF9,0xF9; no overshoot or wrap; 3 beam-on cycles.
- ROM latency, ROM_LATENCY=2 with a registered ROM model: each instruction is captured 3 cycles after rom_addr changes; correct coordinates are used; a stale-data trap in the model is never sampled.
- DOT and implicit END, ADDRESSWIDTH=2:
  - List {DOT(0x40,0x40), MOVE, MOVE, DRAW}, no END word.
  - Required: beam_on high exactly 8 cycles at 0x40.
  - Frame_done fires after address 3; rom_addr returns to 0 and waits for the next frame_tick.
- Enable/tick: deassert enable during the second instruction -> that instruction completes, then IDLE with busy=0. A frame_tick arriving while busy produces no restart and no extra frame_done.
